// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: builds one scanline buffer from the sprite table through a single time-shared fetch path; define SPRITE_COLLISION_EN for overlap detection
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 20,
  parameter int LINE_W = 640,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
  localparam int IW = $clog2(NUM_SPRITES),
  localparam int CW = $clog2(SPRITE_W),
  localparam int RW = $clog2(SPRITE_H),
  localparam int AW = 5 + RW + CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [9:0]    next_line,
  output logic [IW-1:0] ent_idx,
  input  logic [23:0]   ent_data,
  output logic [AW-1:0] rom_addr,
  input  logic [23:0]   rom_data,
  output logic          lb_we,
  output logic [9:0]    lb_addr,
  output logic [23:0]   lb_wdata,
  output logic          busy,
  output logic          done,
  output logic          overrun
`ifdef SPRITE_COLLISION_EN
  ,
  output logic          collision,
  output logic [IW-1:0] coll_idx
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, RD, CHK, FETCH, DRAIN, FIN} state_t;
  state_t state;
  logic [9:0] l, ca, sx, d;
  logic [10:0] wsum;
  logic [CW-1:0] col, wcol;
  logic wr, wr_we, hit, nxt;
  assign col = rom_addr[CW-1:0];
  // hit test on the returned entry and the one-cycle-late pixel write path
  always_comb begin
    d = l - {1'b0, ent_data[13:5]};
    hit = ent_data[4:0] != 5'd0 && l >= {1'b0, ent_data[13:5]} && d < 10'(SPRITE_H);
    nxt = (state == CHK && !hit) || state == DRAIN;
    wsum = {1'b0, sx} + 11'(wcol);
    wr_we = wr && rom_data != TRANSPARENT && wsum < 11'(LINE_W);
    lb_we = state == CLEAR || wr_we;
    lb_addr = state == CLEAR ? ca : wr ? wsum[9:0] : 10'd0;
    lb_wdata = state == CLEAR ? BG_COLOR : wr ? rom_data : 24'd0;
  end
  // sequencer: clear, scan entries high to low, fetch one ROM row per hit
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      l <= '0;
      ca <= '0;
      sx <= '0;
      wr <= 1'b0;
      wcol <= '0;
      ent_idx <= '0;
      rom_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      overrun <= 1'b0;
      wr <= state == FETCH;
      wcol <= col;
      if (line_start) begin
        overrun <= busy;
        l <= next_line;
        ca <= '0;
        wr <= 1'b0;
        busy <= 1'b1;
        state <= CLEAR;
      end else if (nxt) begin
        state <= ent_idx == '0 ? FIN : RD;
        ent_idx <= ent_idx == '0 ? ent_idx : ent_idx - 1'b1;
        done <= ent_idx == '0;
        busy <= ent_idx != '0;
      end else
        case (state)
          CLEAR: begin
            ca <= ca + 10'd1;
            ent_idx <= IW'(NUM_SPRITES - 1);
            state <= ca == 10'(LINE_W - 1) ? RD : CLEAR;
          end
          RD: state <= CHK;
          CHK: begin
            sx <= ent_data[23:14];
            rom_addr <= {ent_data[4:0], d[RW-1:0], {CW{1'b0}}};
            state <= FETCH;
          end
          FETCH: begin
            rom_addr[CW-1:0] <= col + 1'b1;
            state <= col == CW'(SPRITE_W - 1) ? DRAIN : FETCH;
          end
          default: state <= IDLE;
        endcase
    end
`ifdef SPRITE_COLLISION_EN
  logic [LINE_W-1:0] own;
  // pixels already claimed by a sprite on the line being built
  always_ff @(posedge clk or negedge reset)
    if (!reset) own <= '0;
    else if (state == CLEAR) own <= '0;
    else if (wr_we) own[lb_addr] <= 1'b1;
  assign collision = wr_we && own[lb_addr];
  assign coll_idx = collision ? ent_idx : '0;
`endif
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed self-checking bench for sprite_line_scheduler
module tb_sprite_line_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic line_start = 1'b0;
  logic [9:0] next_line = '0;
  logic [4:0] ent_idx;
  logic [23:0] ent_data = '0;
  logic [14:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic lb_we, busy, done, overrun;
  logic [9:0] lb_addr;
  logic [23:0] lb_wdata;
`ifdef SPRITE_COLLISION_EN
  logic collision;
  logic [4:0] coll_idx;
`endif
  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
    .ent_idx(ent_idx), .ent_data(ent_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .busy(busy), .done(done), .overrun(overrun)
`ifdef SPRITE_COLLISION_EN
    , .collision(collision), .coll_idx(coll_idx)
`endif
  );
  always #5 clk = ~clk;
  logic [23:0] tbl [0:19];
  logic [23:0] lb [0:1023];
  logic tr0 = 1'b0;
  int cyc = 0, ls_cyc = 0, total = 0, bad = 0;
  int nclr, clr_err, nsw, sw_min, sw_max, nhi, ndone, nover, ncoll, cbad;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ent_data <= tbl[ent_idx];
    rom_data <= (tr0 && rom_addr[4:0] == 5'd0) ? 24'hFF00FF : {9'h0A5, rom_addr};
  end
  always @(negedge clk) begin
    if (lb_we) begin
      lb[lb_addr] = lb_wdata;
      if (lb_addr >= 10'd640) nhi++;
      if (lb_wdata == 24'h0) begin
        if (lb_addr != 10'(nclr)) clr_err++;
        nclr++;
      end else begin
        nsw++;
        if (int'(lb_addr) < sw_min) sw_min = int'(lb_addr);
        if (int'(lb_addr) > sw_max) sw_max = int'(lb_addr);
      end
    end
    if (done) ndone++;
    if (overrun) nover++;
`ifdef SPRITE_COLLISION_EN
    if (collision) begin
      ncoll++;
      if (coll_idx != 5'd0) cbad++;
    end
`endif
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic zero_cnt;
    nclr = 0; clr_err = 0; nsw = 0; sw_min = 9999; sw_max = -1; nhi = 0;
    ndone = 0; nover = 0; ncoll = 0; cbad = 0;
  endtask
  task automatic clr_tbl;
    for (int i = 0; i < 20; i++) tbl[i] = 24'h0;
    for (int i = 0; i < 1024; i++) lb[i] = 24'h123456;
  endtask
  task automatic start_line(input int ln);
    tick;
    line_start = 1'b1;
    next_line = 10'(ln);
    ls_cyc = cyc;
    zero_cnt;
    tick;
    line_start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 3000 && lat < 0; i++)
      if (done) lat = cyc - ls_cyc;
      else tick;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      line_start = ~line_start;
      next_line = 10'(i);
      total++;
      if ({busy, done, overrun, lb_we, ent_idx, rom_addr, lb_addr, lb_wdata} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b ovr=%b we=%b idx=%0d rom=%h addr=%0d wd=%h want all 0",
                 i, busy, done, overrun, lb_we, ent_idx, rom_addr, lb_addr, lb_wdata);
      end
    end
    line_start = 1'b0;
    tick;
    reset = 1'b1;
    tick;
  endtask
  task automatic test_empty;
    int nz;
    clr_tbl;
    start_line(10);
    total++;
    if (busy !== 1'b1 || lb_we !== 1'b1 || lb_addr !== 10'd0) begin
      bad++;
      $display("FAIL empty_first busy=%b we=%b addr=%0d want 1 1 0", busy, lb_we, lb_addr);
    end
    repeat (640) tick;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (ent_idx !== 5'(19 - k) || lb_we !== 1'b0) begin
        bad++;
        $display("FAIL empty_idx k=%0d got idx=%0d we=%b want idx=%0d we=0", k, ent_idx, lb_we, 19 - k);
      end
      repeat (2) tick;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cyc - ls_cyc != 681) begin
      bad++;
      $display("FAIL empty_done got done=%b busy=%b lat=%0d want 1 0 681", done, busy, cyc - ls_cyc);
    end
    nz = 0;
    for (int i = 0; i < 640; i++) if (lb[i] !== 24'h0) nz++;
    total++;
    if (nclr != 640 || clr_err != 0 || nz != 0 || nsw != 0) begin
      bad++;
      $display("FAIL empty_clear got writes=%0d seq_err=%0d nonbg=%0d spr=%0d want 640 0 0 0", nclr, clr_err, nz, nsw);
    end
    tick;
  endtask
  task automatic test_hit;
    int lat, e;
    logic [23:0] exp;
    clr_tbl;
    tbl[19] = {10'd100, 9'd5, 5'd3};
    start_line(10);
    repeat (642) tick;
    e = 0;
    for (int c = 0; c < 32; c++) begin
      if (rom_addr !== {5'd3, 5'd5, 5'(c)}) e++;
      tick;
    end
    total++;
    if (e != 0) begin
      bad++;
      $display("FAIL hit_rom_addr got %0d wrong addresses want 0", e);
    end
    wait_done(lat);
    total++;
    if (lat != 714) begin
      bad++;
      $display("FAIL hit_latency got %0d want 714", lat);
    end
    e = 0;
    for (int c = 0; c < 32; c++) begin
      exp = {9'h0A5, 5'd3, 5'd5, 5'(c)};
      if (lb[100 + c] !== exp) e++;
    end
    total++;
    if (e != 0 || nsw != 32 || lb[99] !== 24'h0 || lb[132] !== 24'h0) begin
      bad++;
      $display("FAIL hit_pixels got bad=%0d writes=%0d lb99=%h lb132=%h want 0 32 0 0", e, nsw, lb[99], lb[132]);
    end
`ifdef SPRITE_COLLISION_EN
    total++;
    if (ncoll != 0) begin
      bad++;
      $display("FAIL hit_collision got %0d want 0", ncoll);
    end
`endif
    tick;
    start_line(37);
    wait_done(lat);
    total++;
    if (lat != 681 || nsw != 0 || lb[100] !== 24'h0) begin
      bad++;
      $display("FAIL miss_d32 got lat=%0d writes=%0d lb100=%h want 681 0 0", lat, nsw, lb[100]);
    end
    tick;
  endtask
  task automatic test_clip;
    int lat;
    clr_tbl;
    tbl[19] = {10'd620, 9'd0, 5'd7};
    tr0 = 1'b1;
    start_line(3);
    wait_done(lat);
    total++;
    if (lat != 714 || nsw != 19 || sw_min != 621 || sw_max != 639 || nhi != 0) begin
      bad++;
      $display("FAIL clip got lat=%0d writes=%0d min=%0d max=%0d hi=%0d want 714 19 621 639 0",
               lat, nsw, sw_min, sw_max, nhi);
    end
    total++;
    if (lb[620] !== 24'h0 || lb[639] !== {9'h0A5, 5'd7, 5'd3, 5'd19}) begin
      bad++;
      $display("FAIL clip_edges got lb620=%h lb639=%h want 0 %h", lb[620], lb[639], {9'h0A5, 5'd7, 5'd3, 5'd19});
    end
    tr0 = 1'b0;
    tick;
  endtask
  task automatic test_overlap;
    int lat;
    clr_tbl;
    tbl[0] = {10'd50, 9'd0, 5'd2};
    tbl[1] = {10'd50, 9'd0, 5'd4};
    start_line(0);
    wait_done(lat);
    total++;
    if (lat != 747 || nsw != 64) begin
      bad++;
      $display("FAIL overlap_timing got lat=%0d writes=%0d want 747 64", lat, nsw);
    end
    total++;
    if (lb[50] !== {9'h0A5, 5'd2, 5'd0, 5'd0} || lb[81] !== {9'h0A5, 5'd2, 5'd0, 5'd31}) begin
      bad++;
      $display("FAIL overlap_winner got lb50=%h lb81=%h want %h %h",
               lb[50], lb[81], {9'h0A5, 5'd2, 5'd0, 5'd0}, {9'h0A5, 5'd2, 5'd0, 5'd31});
    end
`ifdef SPRITE_COLLISION_EN
    total++;
    if (ncoll != 32 || cbad != 0) begin
      bad++;
      $display("FAIL overlap_collision got pulses=%0d bad_idx=%0d want 32 0", ncoll, cbad);
    end
`endif
    tick;
  endtask
  task automatic test_overrun;
    int lat;
    clr_tbl;
    start_line(10);
    repeat (299) tick;
    total++;
    if (lb_addr !== 10'd299 || lb_we !== 1'b1) begin
      bad++;
      $display("FAIL overrun_pre got addr=%0d we=%b want 299 1", lb_addr, lb_we);
    end
    line_start = 1'b1;
    next_line = 10'd20;
    ls_cyc = cyc;
    tick;
    line_start = 1'b0;
    zero_cnt;
    total++;
    if (overrun !== 1'b1 || lb_addr !== 10'd0 || lb_we !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL overrun_restart got ovr=%b addr=%0d we=%b busy=%b want 1 0 1 1", overrun, lb_addr, lb_we, busy);
    end
    wait_done(lat);
    repeat (5) tick;
    total++;
    if (lat != 681 || ndone != 1 || nover != 1 || nclr != 640 || clr_err != 0) begin
      bad++;
      $display("FAIL overrun_second got lat=%0d dones=%0d ovr=%0d clr=%0d seq_err=%0d want 681 1 1 640 0",
               lat, ndone, nover, nclr, clr_err);
    end
  endtask
  task automatic test_back_to_back;
    int lat;
    clr_tbl;
    start_line(1);
    wait_done(lat);
    line_start = 1'b1;
    next_line = 10'd2;
    ls_cyc = cyc;
    tick;
    line_start = 1'b0;
    zero_cnt;
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1 || lb_addr !== 10'd0 || lb_we !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start got ovr=%b busy=%b addr=%0d we=%b want 0 1 0 1", overrun, busy, lb_addr, lb_we);
    end
    wait_done(lat);
    total++;
    if (lat != 681 || nover != 0) begin
      bad++;
      $display("FAIL b2b_done got lat=%0d ovr=%0d want 681 0", lat, nover);
    end
    tick;
  endtask
  task automatic test_reset_mid;
    clr_tbl;
    tbl[19] = {10'd10, 9'd0, 5'd1};
    start_line(0);
    repeat (645) tick;
    reset = 1'b0;
    #1;
    total++;
    if (lb_we !== 1'b0 || busy !== 1'b0 || rom_addr !== 15'd0 || ent_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid got we=%b busy=%b rom=%h idx=%0d want 0 0 0 0", lb_we, busy, rom_addr, ent_idx);
    end
    zero_cnt;
    repeat (3) tick;
    reset = 1'b1;
    repeat (40) tick;
    total++;
    if (ndone != 0 || nclr != 0 || nsw != 0) begin
      bad++;
      $display("FAIL reset_mid_idle got dones=%0d clr=%0d spr=%0d want 0 0 0", ndone, nclr, nsw);
    end
  endtask
  initial begin
    zero_cnt;
    clr_tbl;
    test_reset;
    test_empty;
    test_hit;
    test_clip;
    test_overlap;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
